ma_lsu_stage: RTL and testbench

Memory-access stage of the 5-stage RV32I pipeline. It sits between the EX/MA register and the MA_WB register. It performs loads and stores over a req/gnt/rvalid data-memory bus, including byte/half lane alignment, sign/zero extension and misalignment detection. While a memory transaction is outstanding it stalls everything upstream and presents bubbles (RegWEn_out=0) to MA_WB.

---
 rtl/rv32i_pkg.sv | 39 +++
 rtl/lsu_align.sv | 61 ++++++
 rtl/ma_lsu_stage.sv | 169 ++++++++++++++++
 tb/tb_ma_lsu_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory-access stage: funct3 and write-back
// select encodings, the LSU state enum and an access-size decoder.
package rv32i_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    localparam logic [1:0] WBSEL_MEM = 2'b00;
    localparam logic [1:0] WBSEL_ALU = 2'b01;
    localparam logic [1:0] WBSEL_PC  = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } acc_size_e;

    // Any funct3 that is not a byte or half access behaves as a word access.
    function automatic acc_size_e access_size(input logic [2:0] f3);
        acc_size_e s;
        case (f3)
            FUNCT3_LB, FUNCT3_LBU: s = SIZE_B;
            FUNCT3_LH, FUNCT3_LHU: s = SIZE_H;
            default:               s = SIZE_W;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / replicated write data,
// load extraction with sign/zero extension, and misalignment detection.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] dataw,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    acc_size_e   size;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign size = access_size(funct3);

    always_comb begin
        misaligned = 1'b0;
        case (size)
            SIZE_H:  misaligned = addr_lo[0];
            SIZE_W:  misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        be = 4'b1111;
        case (size)
            SIZE_B:  be = 4'b0001 << addr_lo;
            SIZE_H:  be = 4'b0011 << addr_lo;
            default: be = 4'b1111;
        endcase
    end

    // Every lane carries the data it would need at any legal offset; be picks the live ones.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
        assign wdata[8*gi +: 8] = (size == SIZE_B) ? dataw[7:0] :
                                  (size == SIZE_H) ? dataw[8*(gi%2) +: 8] :
                                                     dataw[8*gi +: 8];
    end

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        rdata_ext = rdata;
        case (funct3)
            FUNCT3_LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            FUNCT3_LBU: rdata_ext = {24'd0, byte_sel};
            FUNCT3_LH:  rdata_ext = {{16{half_sel[15]}}, half_sel};
            FUNCT3_LHU: rdata_ext = {16'd0, half_sel};
            default:    rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/ma_lsu_stage.sv
// Memory-access pipeline stage: a req/gnt/rvalid load/store FSM with holding
// registers that stalls upstream and emits bubbles while a transaction is open.
module ma_lsu_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            MemEn_in,
    input  logic            MemRW_in,
    input  logic [2:0]      funct3_in,
    input  logic            RegWEn_in,
    input  logic [1:0]      WBSel_in,
    input  logic [4:0]      AddrD_in,
    input  logic [XLEN-1:0] ALU_Result_in,
    input  logic [XLEN-1:0] DataW_in,
    input  logic [XLEN-1:0] pcPlus4_in,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall,
    output logic            misalign_err,
    output logic            RegWEn_out,
    output logic [1:0]      WBSel_out,
    output logic [4:0]      AddrD_out,
    output logic [XLEN-1:0] DataR_out,
    output logic [XLEN-1:0] ALU_Result_out,
    output logic [XLEN-1:0] pcPlus4_out
);

    lsu_state_e      state_reg, state_next;
    logic            we_reg;
    logic [2:0]      funct3_reg;
    logic            regwen_reg;
    logic [1:0]      wbsel_reg;
    logic [4:0]      addrd_reg;
    logic [XLEN-1:0] alu_reg;
    logic [XLEN-1:0] dataw_reg;
    logic [XLEN-1:0] pc4_reg;
    logic [XLEN-1:0] rdata_reg;

    logic            mem_access;
    logic            accept;
    logic [2:0]      al_funct3;
    logic [1:0]      al_addr_lo;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata_ext;
    logic            al_misaligned;

    assign mem_access = valid_in & MemEn_in;

    // In IDLE the aligner judges the incoming instruction; afterwards it serves the held one.
    assign al_funct3  = (state_reg == LSU_IDLE) ? funct3_in : funct3_reg;
    assign al_addr_lo = (state_reg == LSU_IDLE) ? ALU_Result_in[1:0] : alu_reg[1:0];
    assign accept     = (state_reg == LSU_IDLE) & mem_access & ~al_misaligned;

    lsu_align u_align (
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .dataw      (dataw_reg),
        .rdata      (mem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .rdata_ext  (al_rdata_ext),
        .misaligned (al_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) state_reg <= LSU_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LSU_IDLE: if (accept)     state_next = LSU_REQ;
            LSU_REQ:  if (mem_gnt)    state_next = we_reg ? LSU_DONE : LSU_RESP;
            LSU_RESP: if (mem_rvalid) state_next = LSU_DONE;
            LSU_DONE:                 state_next = LSU_IDLE;
            default:                  state_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_reg     <= 1'b0;
            funct3_reg <= 3'd0;
            regwen_reg <= 1'b0;
            wbsel_reg  <= 2'd0;
            addrd_reg  <= 5'd0;
            alu_reg    <= '0;
            dataw_reg  <= '0;
            pc4_reg    <= '0;
            rdata_reg  <= '0;
        end else begin
            if (accept) begin
                we_reg     <= MemRW_in;
                funct3_reg <= funct3_in;
                regwen_reg <= RegWEn_in;
                wbsel_reg  <= WBSel_in;
                addrd_reg  <= AddrD_in;
                alu_reg    <= ALU_Result_in;
                dataw_reg  <= DataW_in;
                pc4_reg    <= pcPlus4_in;
            end
            if (state_reg == LSU_RESP && mem_rvalid) rdata_reg <= al_rdata_ext;
        end
    end

    always_comb begin
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_be         = 4'd0;
        mem_wdata      = '0;
        stall          = 1'b0;
        misalign_err   = 1'b0;
        RegWEn_out     = 1'b0;
        WBSel_out      = 2'd0;
        AddrD_out      = 5'd0;
        DataR_out      = '0;
        ALU_Result_out = '0;
        pcPlus4_out    = '0;
        if (!reset) begin
            if (state_reg == LSU_IDLE) begin
                WBSel_out      = WBSel_in;
                AddrD_out      = AddrD_in;
                ALU_Result_out = ALU_Result_in;
                pcPlus4_out    = pcPlus4_in;
                if (mem_access) begin
                    misalign_err = al_misaligned;
                    stall        = ~al_misaligned;
                end else begin
                    RegWEn_out   = RegWEn_in & valid_in;
                end
            end else begin
                WBSel_out      = wbsel_reg;
                AddrD_out      = addrd_reg;
                ALU_Result_out = alu_reg;
                pcPlus4_out    = pc4_reg;
                case (state_reg)
                    LSU_REQ: begin
                        stall     = 1'b1;
                        mem_req   = 1'b1;
                        mem_we    = we_reg;
                        mem_addr  = {alu_reg[XLEN-1:2], 2'b00};
                        mem_be    = al_be;
                        mem_wdata = al_wdata;
                    end
                    LSU_RESP: stall = 1'b1;
                    LSU_DONE: begin
                        RegWEn_out = regwen_reg;
                        DataR_out  = we_reg ? '0 : rdata_reg;
                    end
                    default: stall = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ma_lsu_stage.sv
// Directed bench for ma_lsu_stage: a per-cycle expectation model built from
// access-size arithmetic, checked every cycle, plus literal pins on key results.
module tb_ma_lsu_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, MemEn_in, MemRW_in, RegWEn_in;
    logic [2:0]  funct3_in;
    logic [1:0]  WBSel_in;
    logic [4:0]  AddrD_in;
    logic [31:0] ALU_Result_in, DataW_in, pcPlus4_in;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall, misalign_err, RegWEn_out;
    logic [1:0]  WBSel_out;
    logic [4:0]  AddrD_out;
    logic [31:0] DataR_out, ALU_Result_out, pcPlus4_out;

    ma_lsu_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .MemEn_in(MemEn_in),
        .MemRW_in(MemRW_in), .funct3_in(funct3_in), .RegWEn_in(RegWEn_in),
        .WBSel_in(WBSel_in), .AddrD_in(AddrD_in), .ALU_Result_in(ALU_Result_in),
        .DataW_in(DataW_in), .pcPlus4_in(pcPlus4_in), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall(stall), .misalign_err(misalign_err), .RegWEn_out(RegWEn_out),
        .WBSel_out(WBSel_out), .AddrD_out(AddrD_out), .DataR_out(DataR_out),
        .ALU_Result_out(ALU_Result_out), .pcPlus4_out(pcPlus4_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outputs for the current cycle; e_fields/e_bus gate the groups that are defined.
    bit          chk_on = 1'b0;
    bit          e_zero, e_fields, e_bus;
    logic        e_stall, e_req, e_mis, e_regwen, e_we;
    logic [1:0]  e_wbsel;
    logic [4:0]  e_addrd;
    logic [3:0]  e_be;
    logic [31:0] e_datar, e_alu, e_pc4, e_addr, e_wdata;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        if (sz == 4) return 4'hF;
        return 4'((sz == 1 ? 1 : 3) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz = m_size(f3);
        if (sz == 1) return (d % 256) * 32'h0101_0101;
        if (sz == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int sz = m_size(f3);
        logic [31:0] w, v, full;
        if (sz == 4) return rd;
        w    = rd >> (8 * (a % 4));
        full = (sz == 1) ? 32'd256 : 32'd65536;
        v    = w % full;
        if (f3[2] == 1'b0 && v >= full / 2) v = v - full;
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            if (e_zero) begin
                cmp("rst_stall", 32'(stall), 0);
                cmp("rst_mem_req", 32'(mem_req), 0);
                cmp("rst_mem_we", 32'(mem_we), 0);
                cmp("rst_mem_addr", mem_addr, 0);
                cmp("rst_mem_be", 32'(mem_be), 0);
                cmp("rst_mem_wdata", mem_wdata, 0);
                cmp("rst_misalign", 32'(misalign_err), 0);
                cmp("rst_regwen", 32'(RegWEn_out), 0);
                cmp("rst_wbsel", 32'(WBSel_out), 0);
                cmp("rst_addrd", 32'(AddrD_out), 0);
                cmp("rst_datar", DataR_out, 0);
                cmp("rst_alu", ALU_Result_out, 0);
                cmp("rst_pc4", pcPlus4_out, 0);
            end else begin
                cmp("stall", 32'(stall), 32'(e_stall));
                cmp("mem_req", 32'(mem_req), 32'(e_req));
                cmp("misalign_err", 32'(misalign_err), 32'(e_mis));
                cmp("RegWEn_out", 32'(RegWEn_out), 32'(e_regwen));
                if (e_fields) begin
                    cmp("WBSel_out", 32'(WBSel_out), 32'(e_wbsel));
                    cmp("AddrD_out", 32'(AddrD_out), 32'(e_addrd));
                    cmp("DataR_out", DataR_out, e_datar);
                    cmp("ALU_Result_out", ALU_Result_out, e_alu);
                    cmp("pcPlus4_out", pcPlus4_out, e_pc4);
                end
                if (e_bus) begin
                    cmp("mem_we", 32'(mem_we), 32'(e_we));
                    cmp("mem_addr", mem_addr, e_addr);
                    cmp("mem_be", 32'(mem_be), 32'(e_be));
                    cmp("mem_wdata", mem_wdata, e_wdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        e_zero = 1'b0; e_fields = 1'b0; e_bus = 1'b0;
        e_stall = 1'b0; e_req = 1'b0; e_mis = 1'b0; e_regwen = 1'b0; e_we = 1'b0;
        e_wbsel = 2'd0; e_addrd = 5'd0; e_be = 4'd0;
        e_datar = '0; e_alu = '0; e_pc4 = '0; e_addr = '0; e_wdata = '0;
    endtask

    task automatic set_in(input logic v, input logic me, input logic rw, input logic [2:0] f3,
                          input logic rwe, input logic [1:0] wbs, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] dw, input logic [31:0] pc4);
        valid_in = v; MemEn_in = me; MemRW_in = rw; funct3_in = f3; RegWEn_in = rwe;
        WBSel_in = wbs; AddrD_in = rd; ALU_Result_in = alu; DataW_in = dw; pcPlus4_in = pc4;
    endtask

    // One idle cycle with a non-memory or invalid instruction; sg/srv inject stray bus handshakes.
    task automatic pass_cycle(input logic v, input logic me, input logic rwe, input logic [1:0] wbs,
                              input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4,
                              input logic sg, input logic srv);
        set_in(v, me, 1'b0, 3'd2, rwe, wbs, rd, alu, $urandom, pc4);
        mem_gnt = sg; mem_rvalid = srv; mem_rdata = $urandom;
        clear_exp();
        e_regwen = rwe & v; e_fields = 1'b1;
        e_wbsel = wbs; e_addrd = rd; e_alu = alu; e_pc4 = pc4; e_datar = '0;
        $display("txn pass valid=%0d memen=%0d rd=%0d alu=0x%08h", v, me, rd, alu);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic mem_op(input logic rw, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] dw, input logic [31:0] rdat,
                          input int gw, input int rvw,
                          input bit lit_d_en, input logic [31:0] lit_d,
                          input bit lit_bus_en, input logic [3:0] lit_be, input logic [31:0] lit_wd);
        logic        rwe;
        logic [1:0]  wbs;
        logic [31:0] pc4;
        rwe = ~rw;
        wbs = rw ? 2'b01 : 2'b00;
        pc4 = $urandom;
        set_in(1'b1, 1'b1, rw, f3, rwe, wbs, rd, addr, dw, pc4);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        clear_exp();
        $display("txn %s f3=%0d addr=0x%08h dataw=0x%08h rdata=0x%08h gnt_wait=%0d rv_wait=%0d",
                 rw ? "store" : "load", f3, addr, dw, rdat, gw, rvw);
        if (m_misaligned(f3, addr)) begin
            e_mis = 1'b1;
            tick();
            return;
        end
        e_stall = 1'b1;
        tick();
        for (int k = 0; k <= gw; k++) begin
            mem_gnt = (k == gw);
            e_req = 1'b1; e_bus = 1'b1; e_we = rw;
            e_addr = addr & ~32'd3; e_be = m_be(f3, addr); e_wdata = m_wdata(f3, dw);
            if (lit_bus_en && k == gw) begin
                @(negedge clk); #1;
                cmp("lit_mem_be", 32'(mem_be), 32'(lit_be));
                cmp("lit_mem_wdata", mem_wdata, lit_wd);
            end
            tick();
        end
        mem_gnt = 1'b0; e_req = 1'b0; e_bus = 1'b0;
        if (!rw) begin
            for (int j = 0; j <= rvw; j++) begin
                mem_rvalid = (j == rvw);
                mem_rdata  = (j == rvw) ? rdat : $urandom;
                tick();
            end
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        e_stall = 1'b0; e_regwen = rwe; e_fields = 1'b1;
        e_wbsel = wbs; e_addrd = rd; e_alu = addr; e_pc4 = pc4;
        e_datar = rw ? 32'd0 : m_load(f3, addr, rdat);
        if (lit_d_en) begin
            @(negedge clk); #1;
            cmp("lit_DataR_out", DataR_out, lit_d);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 2'b01, 5'd3, 32'h55, 32'h66, 32'h77);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        clear_exp();
        e_zero = 1'b1;
        chk_on = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Non-memory pass-through and an invalid memory op.
        pass_cycle(1'b1, 1'b0, 1'b1, 2'b01, 5'd5, 32'h0000_1234, 32'h0000_0044, 1'b0, 1'b0);
        pass_cycle(1'b0, 1'b1, 1'b1, 2'b00, 5'd7, 32'h0000_0200, 32'h0000_0048, 1'b0, 1'b0);

        mem_op(1'b1, 3'd2, 5'd0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0,
               1'b0, 32'h0, 1'b1, 4'b1111, 32'hDEAD_BEEF);
        pass_cycle(1'b1, 1'b0, 1'b1, 2'b10, 5'd9, 32'h0000_0ABC, 32'h0000_0050, 1'b1, 1'b0);

        mem_op(1'b0, 3'd0, 5'd10, 32'h0000_0103, 32'h0, 32'h80FF_0000, 2, 2,
               1'b1, 32'hFFFF_FF80, 1'b0, 4'd0, 32'h0);
        mem_op(1'b0, 3'd4, 5'd11, 32'h0000_0103, 32'h0, 32'h80FF_0000, 2, 2,
               1'b1, 32'h0000_0080, 1'b0, 4'd0, 32'h0);

        mem_op(1'b1, 3'd1, 5'd0, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 1, 0,
               1'b0, 32'h0, 1'b1, 4'b1100, 32'hABCD_ABCD);
        mem_op(1'b0, 3'd1, 5'd12, 32'h0000_0101, 32'h0, 32'h1234_5678, 0, 0,
               1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
        pass_cycle(1'b1, 1'b0, 1'b1, 2'b01, 5'd13, 32'h0000_0007, 32'h0000_0058, 1'b0, 1'b0);

        mem_op(1'b0, 3'd5, 5'd14, 32'h0000_0102, 32'h0, 32'h80FF_0000, 0, 1,
               1'b1, 32'h0000_80FF, 1'b0, 4'd0, 32'h0);
        mem_op(1'b0, 3'd1, 5'd15, 32'h0000_0100, 32'h0, 32'h1234_8001, 1, 0,
               1'b1, 32'hFFFF_8001, 1'b0, 4'd0, 32'h0);
        mem_op(1'b0, 3'd2, 5'd16, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 0, 0,
               1'b1, 32'hCAFE_F00D, 1'b0, 4'd0, 32'h0);
        mem_op(1'b1, 3'd0, 5'd0, 32'h0000_0101, 32'h1234_5678, 32'h0, 0, 0,
               1'b0, 32'h0, 1'b1, 4'b0010, 32'h7878_7878);
        mem_op(1'b1, 3'd2, 5'd0, 32'h0000_0102, 32'h1111_2222, 32'h0, 0, 0,
               1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
        mem_op(1'b0, 3'd3, 5'd17, 32'h0000_0108, 32'h0, 32'h8765_4321, 0, 0,
               1'b1, 32'h8765_4321, 1'b0, 4'd0, 32'h0);
        mem_op(1'b0, 3'd7, 5'd18, 32'h0000_0109, 32'h0, 32'h0, 0, 0,
               1'b0, 32'h0, 1'b0, 4'd0, 32'h0);

        // Reset while waiting for read data, then a stray rvalid in IDLE.
        $display("txn load f3=2 addr=0x00000200 interrupted by reset in RESP");
        set_in(1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 2'b00, 5'd20, 32'h0000_0200, 32'h0, 32'h0000_0300);
        clear_exp();
        e_stall = 1'b1;
        tick();
        mem_gnt = 1'b1;
        e_req = 1'b1; e_bus = 1'b1; e_we = 1'b0; e_addr = 32'h0000_0200;
        e_be = 4'hF; e_wdata = 32'h0;
        tick();
        mem_gnt = 1'b0; e_req = 1'b0; e_bus = 1'b0;
        tick();
        reset = 1'b1;
        clear_exp();
        e_zero = 1'b1;
        tick(); tick();
        reset = 1'b0;
        pass_cycle(1'b1, 1'b0, 1'b1, 2'b01, 5'd21, 32'h0000_4321, 32'h0000_0304, 1'b0, 1'b1);
        pass_cycle(1'b1, 1'b0, 1'b1, 2'b01, 5'd22, 32'h0000_9999, 32'h0000_0308, 1'b0, 1'b0);
        mem_op(1'b1, 3'd2, 5'd0, 32'h0000_0400, 32'h0BAD_CAFE, 32'h0, 0, 0,
               1'b0, 32'h0, 1'b1, 4'b1111, 32'h0BAD_CAFE);
        pass_cycle(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
